// File: rtl/uart_pkg.sv
// Shared constants for the UART receive controller: register map, STATUS/CTRL
// bit positions and the divisor width.
package uart_pkg;

  localparam int DIV_W = 16;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int ST_EMPTY   = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_OVERRUN = 16;
  localparam int ST_TIMEOUT = 17;

  localparam int CT_EN     = 0;
  localparam int CT_IE_RX  = 1;
  localparam int CT_IE_OVR = 2;
  localparam int CT_IE_TO  = 3;
  localparam int CT_THR_LO = 8;

  // A divisor below 2 cannot place a mid-bit sample, so it behaves as 2.
  function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W-1:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator, byte capture into the RX FIFO,
// CPU register port and level interrupt. Idle timeout under UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int               FIFO_DEPTH = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
`ifdef UART_RX_CTRL_TIMEOUT_EN
  ,
  parameter int               TO_BITS    = 10
`endif
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        rx_bps_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        clk_uart,
  input  logic        reg_sel,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic             en_q, ie_rx_q, ie_ovr_q, overrun_q, rx_done_q;
  logic [7:0]       thresh_q, thr_eff, fifo_dout;
  logic [DIV_W-1:0] div_q, div_act, cnt;
  logic [LW-1:0]    fifo_level;
  logic [8:0]       level9;
  logic             fifo_full, fifo_empty;
  logic             tick_active, push, pop, drop;
  logic             wr_ctrl, wr_status, wr_div;
  logic [31:0]      rd_mux;
  logic             irq_next;
  logic             unused_ok;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic             ie_to_q, timeout_q, to_fire;
  logic [31:0]      to_cnt, to_lim;
`endif

  // Register port: reg_sel is a single-cycle strobe with no back-pressure.
  // Writes commit on that edge; read data is registered on that edge and is
  // valid in the following cycle, holding until the next read.
  assign wr_ctrl   = reg_sel & reg_we & (reg_addr == ADDR_CTRL);
  assign wr_status = reg_sel & reg_we & (reg_addr == ADDR_STATUS);
  assign wr_div    = reg_sel & reg_we & (reg_addr == ADDR_DIV);
  assign pop       = reg_sel & ~reg_we & (reg_addr == ADDR_DATA) & ~fifo_empty;

  assign push = rx_done & ~rx_done_q & en_q;
  assign drop = push & fifo_full & ~pop;

  assign level9    = 9'(fifo_level);
  assign thr_eff   = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
  assign unused_ok = ^reg_wdata;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .RSTn  (RSTn),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The divisor is sampled only while idle, so a DIV write lands at the next frame.
  assign tick_active = en_q & rx_bps_en;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt      <= '0;
      div_act  <= div_clamp(DIV_RESET);
      clk_uart <= 1'b0;
    end else if (!tick_active) begin
      cnt      <= '0;
      div_act  <= div_clamp(div_q);
      clk_uart <= 1'b0;
    end else begin
      clk_uart <= (cnt == (div_act >> 1));
      cnt      <= (cnt == div_act - 16'd1) ? '0 : cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) rx_done_q <= 1'b0;
    else       rx_done_q <= rx_done;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      en_q     <= 1'b0;
      ie_rx_q  <= 1'b0;
      ie_ovr_q <= 1'b0;
      thresh_q <= 8'd0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      ie_to_q  <= 1'b0;
`endif
    end else if (wr_ctrl) begin
      en_q     <= reg_wdata[CT_EN];
      ie_rx_q  <= reg_wdata[CT_IE_RX];
      ie_ovr_q <= reg_wdata[CT_IE_OVR];
      thresh_q <= reg_wdata[CT_THR_LO +: 8];
`ifdef UART_RX_CTRL_TIMEOUT_EN
      ie_to_q  <= reg_wdata[CT_IE_TO];
`endif
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)       div_q <= DIV_RESET;
    else if (wr_div) div_q <= reg_wdata[DIV_W-1:0];
  end

  // A new overrun in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)                                    overrun_q <= 1'b0;
    else if (drop)                                overrun_q <= 1'b1;
    else if (wr_status && reg_wdata[ST_OVERRUN])  overrun_q <= 1'b0;
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  assign to_lim  = 32'(TO_BITS) * {16'h0, div_clamp(div_q)};
  assign to_fire = ~(push | pop) & ~fifo_empty & ~rx_bps_en & (to_cnt == to_lim - 32'd1);

  // Counts idle time with data waiting; saturates at the limit so it fires once.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)                                            to_cnt <= '0;
    else if (push || pop)                                 to_cnt <= '0;
    else if (!fifo_empty && !rx_bps_en && to_cnt < to_lim) to_cnt <= to_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)                                   timeout_q <= 1'b0;
    else if (to_fire)                            timeout_q <= 1'b1;
    else if (wr_status && reg_wdata[ST_TIMEOUT]) timeout_q <= 1'b0;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_DATA: rd_mux = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
      ADDR_STATUS: begin
        rd_mux[ST_OVERRUN] = overrun_q;
        rd_mux[ST_FULL]    = fifo_full;
        rd_mux[ST_EMPTY]   = fifo_empty;
        rd_mux[7:0]        = level9[7:0];
`ifdef UART_RX_CTRL_TIMEOUT_EN
        rd_mux[ST_TIMEOUT] = timeout_q;
`endif
      end
      ADDR_CTRL: begin
        rd_mux[CT_THR_LO +: 8] = thresh_q;
        rd_mux[CT_IE_OVR]      = ie_ovr_q;
        rd_mux[CT_IE_RX]       = ie_rx_q;
        rd_mux[CT_EN]          = en_q;
`ifdef UART_RX_CTRL_TIMEOUT_EN
        rd_mux[CT_IE_TO]       = ie_to_q;
`endif
      end
      default: rd_mux = {16'h0, div_q};
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)                  reg_rdata <= '0;
    else if (reg_sel && !reg_we) reg_rdata <= rd_mux;
  end

  always_comb begin
    irq_next = (ie_rx_q & (level9 >= {1'b0, thr_eff})) | (ie_ovr_q & overrun_q);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    irq_next = irq_next | (ie_to_q & timeout_q);
`endif
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) irq <= 1'b0;
    else       irq <= irq_next;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: register reset values, baud tick timing,
// threshold/overrun interrupts, FIFO ordering and async reset.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        rx_bps_en = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        clk_uart;
  logic        reg_sel = 1'b0;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;
  logic        irq;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd;
  logic [31:0] exp_ctrl;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .rx_bps_en (rx_bps_en),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .clk_uart  (clk_uart),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_sel = 1'b0; reg_we = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_sel = 1'b1; reg_we = 1'b0; reg_addr = a;
    tick();
    reg_sel = 1'b0;
    d = reg_rdata;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic keep);
    rx_data = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    if (keep) exp_q.push_back(b);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] v;
    reg_read(2'd0, v);
    if (exp_q.size() == 0) check(tag, v, 32'h0);
    else                   check(tag, v, {24'h0, exp_q.pop_front()});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset and idle register values
    repeat (3) tick();
    check("rst_clk_uart", {31'h0, clk_uart}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);
    RSTn = 1'b1;
    tick();
    reg_read(2'd3, rd); check("rst_div", rd, 32'd434);
    reg_read(2'd2, rd); check("rst_ctrl", rd, 32'h0);
    reg_read(2'd1, rd); check("rst_status", rd, 32'h100);
    read_data("empty_data");
    reg_read(2'd1, rd); check("empty_read_no_pop", rd, 32'h100);
    reg_write(2'd0, 32'h55);
    reg_read(2'd1, rd); check("data_write_ignored", rd, 32'h100);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    exp_ctrl = 32'h0000_AB0F;
`else
    exp_ctrl = 32'h0000_AB07;
`endif
    reg_write(2'd2, 32'hFFFF_AB0F);
    reg_read(2'd2, rd); check("ctrl_rw", rd, exp_ctrl);
    reg_write(2'd2, 32'h0);

    // Baud ticks with DIV=10: first at cycle 5, then every 10
    reg_write(2'd3, 32'd10);
    reg_write(2'd2, 32'h1);
    rx_bps_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check($sformatf("tick_div10_c%0d", i), {31'h0, clk_uart},
            {31'h0, (i >= 5) && ((i - 5) % 10 == 0)});
    end
    rx_bps_en = 1'b0;
    tick();

    // en dropped mid-frame aborts ticks; captures ignored while disabled
    rx_bps_en = 1'b1;
    repeat (3) tick();
    reg_write(2'd2, 32'h0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("abort_c%0d", i), {31'h0, clk_uart}, 32'h0);
      tick();
    end
    push_byte(8'h99, 1'b0);
    rx_bps_en = 1'b0;
    reg_read(2'd1, rd); check("disabled_no_capture", rd, 32'h100);

    // DIV=1 behaves as DIV=2
    reg_write(2'd3, 32'd1);
    reg_write(2'd2, 32'h1);
    rx_bps_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("tick_div1_c%0d", i), {31'h0, clk_uart}, {31'h0, (i % 2) == 1});
    end
    rx_bps_en = 1'b0;
    reg_write(2'd3, 32'd434);

    // Threshold interrupt at 4 bytes
    reg_write(2'd2, 32'h0403);
    push_byte(8'hA1, 1'b1);
    push_byte(8'hB2, 1'b1);
    push_byte(8'hC3, 1'b1);
    check("irq_below_thresh", {31'h0, irq}, 32'h0);
    push_byte(8'hD4, 1'b1);
    check("irq_at_thresh", {31'h0, irq}, 32'h1);
    reg_read(2'd1, rd); check("status_level4", rd, 32'h004);
    for (int i = 0; i < 4; i++) read_data($sformatf("thr_data%0d", i));
    tick();
    check("irq_after_drain", {31'h0, irq}, 32'h0);

    // thresh=0 acts as 1; level input held high pushes once
    reg_write(2'd2, 32'h0003);
    rx_data = 8'h3C; rx_done = 1'b1;
    repeat (5) tick();
    rx_done = 1'b0;
    exp_q.push_back(8'h3C);
    tick();
    check("irq_thresh0", {31'h0, irq}, 32'h1);
    reg_read(2'd1, rd); check("single_push_per_level", rd, 32'h001);
    read_data("thr0_data");
    tick();
    check("irq_thresh0_clear", {31'h0, irq}, 32'h0);

    // Overrun: 17 pushes into 16 entries
    reg_write(2'd2, 32'h0005);
    for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i), i < 16);
    reg_read(2'd1, rd); check("status_overrun", rd, 32'h10210);
    check("irq_overrun", {31'h0, irq}, 32'h1);
    reg_write(2'd1, 32'h10000);
    reg_read(2'd1, rd); check("overrun_cleared", rd, 32'h210);
    check("irq_overrun_clear", {31'h0, irq}, 32'h0);

    // Simultaneous push and pop while full
    rx_data = 8'h77; rx_done = 1'b1;
    reg_sel = 1'b1; reg_we = 1'b0; reg_addr = 2'd0;
    tick();
    reg_sel = 1'b0; rx_done = 1'b0;
    check("pushpop_head", reg_rdata, {24'h0, exp_q.pop_front()});
    exp_q.push_back(8'h77);
    reg_read(2'd1, rd); check("pushpop_level", rd, 32'h210);
    for (int i = 0; i < 16; i++) read_data($sformatf("drain%0d", i));
    reg_read(2'd1, rd); check("drained_status", rd, 32'h100);

    // Asynchronous reset mid-frame
    reg_write(2'd3, 32'd10);
    reg_write(2'd2, 32'h0103);
    push_byte(8'h5A, 1'b1);
    check("irq_pre_reset", {31'h0, irq}, 32'h1);
    reg_read(2'd1, rd); check("status_pre_reset", rd, 32'h001);
    rx_bps_en = 1'b1;
    repeat (6) tick();
    check("tick_pre_reset", {31'h0, clk_uart}, 32'h1);
    #2 RSTn = 1'b0;
    tick();
    check("arst_clk_uart", {31'h0, clk_uart}, 32'h0);
    check("arst_irq", {31'h0, irq}, 32'h0);
    check("arst_rdata", reg_rdata, 32'h0);
    exp_q.delete();
    rx_bps_en = 1'b0;
    RSTn = 1'b1;
    tick();
    reg_read(2'd1, rd); check("arst_status", rd, 32'h100);
    reg_read(2'd2, rd); check("arst_ctrl", rd, 32'h0);
    reg_read(2'd3, rd); check("arst_div", rd, 32'd434);

    // Idle timeout
    reg_write(2'd3, 32'd10);
    reg_write(2'd2, 32'h0009);
    push_byte(8'hE7, 1'b1);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (irq !== 1'b1 && n < 300) begin
        tick();
        n++;
      end
      check("timeout_latency", 32'(n), 32'd100);
    end
    reg_read(2'd1, rd); check("timeout_status", rd, 32'h20001);
    read_data("timeout_data");
    reg_write(2'd1, 32'h20000);
    tick();
    check("timeout_irq_clear", {31'h0, irq}, 32'h0);
    repeat (150) tick();
    reg_read(2'd1, rd); check("timeout_after_pop", rd, 32'h100);
`else
    repeat (150) tick();
    check("no_timeout_irq", {31'h0, irq}, 32'h0);
    reg_read(2'd1, rd); check("no_timeout_status", rd, 32'h001);
    read_data("no_timeout_data");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
